// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the Riscv151 pipeline. Owns the PC register,
//   drives the synchronous-read BIOS and IMEM instruction ports, and hands
//   decode an aligned {pc, instruction, valid} bundle. It also keeps a count
//   of instructions accepted by decode and a sticky misaligned-target fault.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   stall             hold the current fetch (hazard stall from decode)
//   redirect_valid    execute requests a PC change (JAL/JALR/taken branch)
//   redirect_target   target address from execute (bit 0 ignored)
//   bios_addr/en      BIOS word address and read enable
//   bios_dout         BIOS read data, one-cycle latency
//   imem_addr/en      IMEM word address and read enable
//   imem_dout         IMEM read data, one-cycle latency
//   if_pc/if_inst     PC and instruction presented to decode
//   if_valid          if_inst is on the correct path and legal
//   fault, fault_pc   sticky misaligned-target fault and offending target
//   inst_count        saturating count of instructions accepted by decode
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [11:0] bios_addr,
  output logic        bios_en,
  input  logic [31:0] bios_dout,
  output logic [13:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_dout,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] inst_count
);

  typedef enum logic [1:0] {RESET_S, RUN, FAULT} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic [31:0] tgt;
  logic        fault_redirect;
  logic        region_bios;
  logic        region_imem;

  // JALR semantics: the low bit of every target is dropped.
  assign tgt = redirect_target & ~32'h1;

  // A redirect whose word alignment is broken only traps while running.
  assign fault_redirect = (state == RUN) && redirect_valid && tgt[1];

  // Region of the instruction currently presented (data arrives one cycle
  // after pc_q was issued as the fetch address).
  assign region_bios = (pc_q[31:28] == 4'h4);
  assign region_imem = (pc_q[31:28] == 4'h1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_S;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      RESET_S: state_next = RUN;
      RUN:     state_next = fault_redirect ? FAULT : RUN;
      FAULT:   state_next = FAULT;
      default: state_next = RESET_S;
    endcase
  end

  // Next PC doubles as the fetch address. RESET_S re-issues the reset PC so
  // that the first RUN cycle sees word 0 from the BIOS; a faulting redirect
  // freezes the PC where it is.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (rst) begin
      next_pc = RESET_PC;
    end else if (state == FAULT || state == RESET_S) begin
      next_pc = pc_q;
    end else if (fault_redirect) begin
      next_pc = pc_q;
    end else if (redirect_valid) begin
      next_pc = tgt;
    end else if (stall) begin
      next_pc = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_pc <= '0;
    end else if (fault_redirect) begin
      fault_pc <= tgt;
    end
  end

  // if_valid already excludes redirect-killed instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_count <= '0;
    end else if (if_valid && !stall && (inst_count != 32'hFFFF_FFFF)) begin
      inst_count <= inst_count + 32'd1;
    end
  end

  // Output logic
  always_comb begin
    bios_addr = next_pc[13:2];
    imem_addr = next_pc[15:2];
    bios_en   = (state != FAULT) && (next_pc[31:28] == 4'h4);
    imem_en   = (state != FAULT) && (next_pc[31:28] == 4'h1);
    fault     = (state == FAULT);
    if_pc     = pc_q;
    if_valid  = 1'b0;
    if_inst   = NOP_INST;
    if (rst) begin
      if_pc = RESET_PC;
    end else begin
      if_valid = (state == RUN) && (region_bios || region_imem) && !redirect_valid;
      if (if_valid) begin
        if_inst = region_bios ? bios_dout : imem_dout;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. BIOS and IMEM are modelled as
//   synchronous-read arrays. An architectural model tracks the PC, run/fault
//   status and accepted-instruction count, and predicts each cycle's bundle
//   by looking the PC up directly in the memory arrays.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [11:0] bios_addr;
  logic        bios_en;
  logic [31:0] bios_dout;
  logic [13:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_dout;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] inst_count;

  int tests_run = 0;
  int failed    = 0;

  logic [31:0] bios_mem [4096];
  logic [31:0] imem_mem [16384];

  // Architectural model state and its value after the coming edge
  logic [31:0] m_pc, n_pc, m_count, n_count, m_fault_pc, n_fault_pc;
  logic        m_started, n_started, m_faulted, n_faulted;

  // Expected outputs for the current cycle
  logic [31:0] exp_pc, exp_inst, exp_count, exp_fault_pc;
  logic        exp_valid, exp_nop, exp_fault, exp_bios_en, exp_imem_en;
  logic [11:0] exp_bios_addr;
  logic [13:0] exp_imem_addr;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .bios_addr(bios_addr), .bios_en(bios_en), .bios_dout(bios_dout),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_dout(imem_dout),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
    .fault(fault), .fault_pc(fault_pc), .inst_count(inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bios_en) bios_dout <= bios_mem[bios_addr];
    if (imem_en) imem_dout <= imem_mem[imem_addr];
  end

  // Drive one cycle of inputs, predict the outputs, wait to the negedge.
  task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] rt);
    logic [31:0] t;
    logic [31:0] na;
    logic        ok;
    rst = r; stall = s; redirect_valid = rv; redirect_target = rt;
    t  = {rt[31:1], 1'b0};
    ok = (m_pc[31:28] == 4'h4) || (m_pc[31:28] == 4'h1);
    n_pc = m_pc; n_count = m_count; n_fault_pc = m_fault_pc;
    n_started = m_started; n_faulted = m_faulted;
    exp_fault = m_faulted; exp_fault_pc = m_fault_pc; exp_count = m_count;
    if (r) begin
      exp_pc = RESET_PC; exp_valid = 1'b0; exp_inst = NOP_INST; exp_nop = 1'b1;
      na = RESET_PC;
      n_pc = RESET_PC; n_started = 1'b0; n_faulted = 1'b0;
      n_count = '0; n_fault_pc = '0;
    end else begin
      exp_pc    = m_pc;
      exp_valid = m_started && !m_faulted && ok && !rv;
      exp_nop   = !ok;
      if (m_pc[31:28] == 4'h4)      exp_inst = bios_mem[m_pc[13:2]];
      else if (m_pc[31:28] == 4'h1) exp_inst = imem_mem[m_pc[15:2]];
      else                          exp_inst = NOP_INST;
      if (m_faulted) na = m_pc;
      else if (!m_started) begin na = m_pc; n_started = 1'b1; end
      else if (rv && t[1]) begin na = m_pc; n_faulted = 1'b1; n_fault_pc = t; end
      else if (rv) na = t;
      else if (s)  na = m_pc;
      else         na = m_pc + 32'd4;
      n_pc = na;
      if (exp_valid && !s && (m_count != 32'hFFFF_FFFF)) n_count = m_count + 32'd1;
    end
    exp_bios_en   = !m_faulted && (na[31:28] == 4'h4);
    exp_imem_en   = !m_faulted && (na[31:28] == 4'h1);
    exp_bios_addr = na[13:2];
    exp_imem_addr = na[15:2];
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_pc = n_pc; m_count = n_count; m_fault_pc = n_fault_pc;
    m_started = n_started; m_faulted = n_faulted;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      tests_run++; if (if_valid !== 1'b0) begin failed++; $display("[TB] FAIL rst_valid got %b want 0", if_valid); end
      tests_run++; if (if_inst !== NOP_INST) begin failed++; $display("[TB] FAIL rst_inst got %h want %h", if_inst, NOP_INST); end
      tests_run++; if (if_pc !== RESET_PC) begin failed++; $display("[TB] FAIL rst_pc got %h want %h", if_pc, RESET_PC); end
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tests_run++; if (if_valid !== 1'b0) begin failed++; $display("[TB] FAIL first_run_valid got %b want 0", if_valid); end
    tests_run++; if (inst_count !== 32'd0) begin failed++; $display("[TB] FAIL rst_count got %h want 0", inst_count); end
    tests_run++; if (fault !== 1'b0 || fault_pc !== 32'd0) begin failed++; $display("[TB] FAIL rst_fault got %b/%h want 0/0", fault, fault_pc); end
    tests_run++; if (bios_en !== 1'b1 || bios_addr !== 12'h000) begin failed++; $display("[TB] FAIL rst_bios got %b/%h want 1/000", bios_en, bios_addr); end
    advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tests_run++; if (if_pc !== 32'h4000_0000 || if_valid !== 1'b1) begin failed++; $display("[TB] FAIL word0_pc got %h/%b want 40000000/1", if_pc, if_valid); end
    tests_run++; if (if_inst !== 32'h0C80_0093) begin failed++; $display("[TB] FAIL word0_inst got %h want 0c800093", if_inst); end
    advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tests_run++; if (if_pc !== 32'h4000_0004 || if_valid !== 1'b1) begin failed++; $display("[TB] FAIL word1_pc got %h/%b want 40000004/1", if_pc, if_valid); end
    tests_run++; if (inst_count !== 32'd1) begin failed++; $display("[TB] FAIL word1_count got %h want 1", inst_count); end
    advance();
  endtask

  task automatic test_jal();
    drive(1'b0, 1'b0, 1'b1, 32'h4000_0020);
    tests_run++; if (if_pc !== 32'h4000_0008 || if_valid !== 1'b0) begin failed++; $display("[TB] FAIL jal_kill got %h/%b want 40000008/0", if_pc, if_valid); end
    tests_run++; if (bios_en !== 1'b1 || bios_addr !== 12'h008) begin failed++; $display("[TB] FAIL jal_addr got %b/%h want 1/008", bios_en, bios_addr); end
    advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tests_run++; if (if_pc !== 32'h4000_0020 || if_valid !== 1'b1) begin failed++; $display("[TB] FAIL jal_pc got %h/%b want 40000020/1", if_pc, if_valid); end
    tests_run++; if (if_inst !== bios_mem[8]) begin failed++; $display("[TB] FAIL jal_inst got %h want %h", if_inst, bios_mem[8]); end
    tests_run++; if (inst_count !== 32'd2) begin failed++; $display("[TB] FAIL jal_count got %h want 2", inst_count); end
    advance();
  endtask

  task automatic test_jalr_odd();
    drive(1'b0, 1'b0, 1'b1, 32'h1000_0105);
    tests_run++; if (imem_en !== 1'b1 || imem_addr !== 14'h041 || bios_en !== 1'b0) begin failed++; $display("[TB] FAIL jalr_port got %b/%h/%b want 1/0041/0", imem_en, imem_addr, bios_en); end
    advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tests_run++; if (if_pc !== 32'h1000_0104 || if_valid !== 1'b1) begin failed++; $display("[TB] FAIL jalr_pc got %h/%b want 10000104/1", if_pc, if_valid); end
    tests_run++; if (if_inst !== imem_mem[14'h041]) begin failed++; $display("[TB] FAIL jalr_inst got %h want %h", if_inst, imem_mem[14'h041]); end
    tests_run++; if (fault !== 1'b0) begin failed++; $display("[TB] FAIL jalr_fault got %b want 0", fault); end
    advance();
  endtask

  task automatic test_stall_redirect();
    logic [31:0] c0;
    drive(1'b0, 1'b0, 1'b1, 32'h4000_0010);
    advance();
    c0 = m_count;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tests_run++; if (if_pc !== 32'h4000_0010 || if_valid !== 1'b1) begin failed++; $display("[TB] FAIL stall1_pc got %h/%b want 40000010/1", if_pc, if_valid); end
    tests_run++; if (if_inst !== bios_mem[4]) begin failed++; $display("[TB] FAIL stall1_inst got %h want %h", if_inst, bios_mem[4]); end
    advance();
    drive(1'b0, 1'b1, 1'b1, 32'h4000_0040);
    tests_run++; if (if_pc !== 32'h4000_0010 || if_valid !== 1'b0) begin failed++; $display("[TB] FAIL stall2_pc got %h/%b want 40000010/0", if_pc, if_valid); end
    tests_run++; if (inst_count !== c0) begin failed++; $display("[TB] FAIL stall2_count got %h want %h", inst_count, c0); end
    advance();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tests_run++; if (if_pc !== 32'h4000_0040 || if_valid !== 1'b1) begin failed++; $display("[TB] FAIL stall3_pc got %h/%b want 40000040/1", if_pc, if_valid); end
    tests_run++; if (if_inst !== bios_mem[16]) begin failed++; $display("[TB] FAIL stall3_inst got %h want %h", if_inst, bios_mem[16]); end
    advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tests_run++; if (if_pc !== 32'h4000_0040 || inst_count !== c0) begin failed++; $display("[TB] FAIL stall_exit got %h/%h want 40000040/%h", if_pc, inst_count, c0); end
    advance();
  endtask

  task automatic test_illegal_region();
    drive(1'b0, 1'b0, 1'b1, 32'h2000_0000);
    advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tests_run++; if (if_pc !== 32'h2000_0000 || if_valid !== 1'b0) begin failed++; $display("[TB] FAIL illegal_pc got %h/%b want 20000000/0", if_pc, if_valid); end
    tests_run++; if (if_inst !== NOP_INST) begin failed++; $display("[TB] FAIL illegal_inst got %h want %h", if_inst, NOP_INST); end
    tests_run++; if (bios_en !== 1'b0 || imem_en !== 1'b0) begin failed++; $display("[TB] FAIL illegal_en got %b/%b want 0/0", bios_en, imem_en); end
    advance();
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tests_run++; if (if_pc !== 32'h2000_0004 || fault !== 1'b0) begin failed++; $display("[TB] FAIL illegal_adv got %h/%b want 20000004/0", if_pc, fault); end
    advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    advance();
    drive(1'b0, 1'b0, 1'b1, 32'h4000_0100);
    tests_run++; if (if_pc !== 32'h0000_0000 || if_valid !== 1'b0) begin failed++; $display("[TB] FAIL pc_wrap got %h/%b want 00000000/0", if_pc, if_valid); end
    advance();
  endtask

  task automatic test_random();
    logic        r, s, rv;
    logic [31:0] rt;
    int          sel;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 9) < 3);
      rv  = ($urandom_range(0, 9) < 2);
      sel = $urandom_range(0, 9);
      if (sel < 5)      rt = 32'h4000_0000 | ($urandom & 32'h0000_3FFD);
      else if (sel < 9) rt = 32'h1000_0000 | ($urandom & 32'h0000_FFFD);
      else              rt = $urandom & 32'hFFFF_FFFD;
      drive(r, s, rv, rt);
      tests_run++; if (if_pc !== exp_pc) begin failed++; $display("[TB] FAIL rnd_pc cyc %0d got %h want %h", i, if_pc, exp_pc); end
      tests_run++; if (if_valid !== exp_valid) begin failed++; $display("[TB] FAIL rnd_valid cyc %0d got %b want %b", i, if_valid, exp_valid); end
      if (exp_valid || exp_nop) begin
        tests_run++; if (if_inst !== exp_inst) begin failed++; $display("[TB] FAIL rnd_inst cyc %0d got %h want %h", i, if_inst, exp_inst); end
      end
      if (!r) begin
        tests_run++; if (inst_count !== exp_count) begin failed++; $display("[TB] FAIL rnd_count cyc %0d got %h want %h", i, inst_count, exp_count); end
        tests_run++; if (fault !== exp_fault) begin failed++; $display("[TB] FAIL rnd_fault cyc %0d got %b want %b", i, fault, exp_fault); end
        tests_run++; if (bios_en !== exp_bios_en || imem_en !== exp_imem_en) begin failed++; $display("[TB] FAIL rnd_en cyc %0d got %b%b want %b%b", i, bios_en, imem_en, exp_bios_en, exp_imem_en); end
        if (exp_bios_en) begin
          tests_run++; if (bios_addr !== exp_bios_addr) begin failed++; $display("[TB] FAIL rnd_baddr cyc %0d got %h want %h", i, bios_addr, exp_bios_addr); end
        end
        if (exp_imem_en) begin
          tests_run++; if (imem_addr !== exp_imem_addr) begin failed++; $display("[TB] FAIL rnd_iaddr cyc %0d got %h want %h", i, imem_addr, exp_imem_addr); end
        end
      end
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      advance();
    end
  endtask

  task automatic test_fault();
    logic [31:0] p0;
    p0 = m_pc;
    drive(1'b0, 1'b0, 1'b1, 32'h4000_0022);
    tests_run++; if (if_valid !== 1'b0) begin failed++; $display("[TB] FAIL fault_entry_valid got %b want 0", if_valid); end
    advance();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h4000_0100);
      tests_run++; if (fault !== 1'b1 || fault_pc !== 32'h4000_0022) begin failed++; $display("[TB] FAIL fault_sticky cyc %0d got %b/%h want 1/40000022", i, fault, fault_pc); end
      tests_run++; if (if_valid !== 1'b0 || bios_en !== 1'b0 || imem_en !== 1'b0) begin failed++; $display("[TB] FAIL fault_quiet cyc %0d got %b%b%b want 000", i, if_valid, bios_en, imem_en); end
      tests_run++; if (if_pc !== p0) begin failed++; $display("[TB] FAIL fault_pc_hold cyc %0d got %h want %h", i, if_pc, p0); end
      advance();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tests_run++; if (fault !== 1'b0 || fault_pc !== 32'd0) begin failed++; $display("[TB] FAIL fault_clear got %b/%h want 0/0", fault, fault_pc); end
    tests_run++; if (if_pc !== 32'h4000_0000 || inst_count !== 32'd0) begin failed++; $display("[TB] FAIL fault_rst_pc got %h/%h want 40000000/0", if_pc, inst_count); end
    advance();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++)  bios_mem[i] = $urandom;
    for (int i = 0; i < 16384; i++) imem_mem[i] = $urandom;
    bios_mem[0] = 32'h0C80_0093;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    m_pc = RESET_PC; m_count = '0; m_fault_pc = '0;
    m_started = 1'b0; m_faulted = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_jal();
    test_jalr_odd();
    test_stall_redirect();
    test_illegal_region();
    test_random();
    test_fault();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
